// File: rtl/restoring_divider_if.sv
// Start/Busy/Done handshake bundle between an ALU controller and the restoring divider.
// The controller side takes the master modport; the divider takes the slave modport.
interface restoring_divider_if #(parameter int WIDTH = 4);
  logic             Start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Quotient;
  logic [WIDTH-1:0] Remainder;
  logic             DivZero;

  modport master (output Start, A, B,
                  input  Busy, Done, Quotient, Remainder, DivZero);
  modport slave  (input  Start, A, B,
                  output Busy, Done, Quotient, Remainder, DivZero);
endinterface

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, WIDTH iterations.
// Divide-by-zero is resolved at the Start edge and skips the iteration phase.
module restoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic             Clk,
  input  logic             Rst_n,
  restoring_divider_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t           state;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   prem;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   prem_nxt;
  logic [WIDTH-1:0] dvd_nxt;
  logic             qbit;

  // Partial remainder always stays below the divisor, so its shifted form fits WIDTH+1 bits.
  always_comb begin
    shifted  = {prem[WIDTH-1:0], dvd[WIDTH-1]};
    trial    = shifted - {1'b0, dvs};
    qbit     = ~trial[WIDTH];
    prem_nxt = qbit ? trial : shifted;
    dvd_nxt  = {dvd[WIDTH-2:0], qbit};
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state         <= IDLE;
      dvd           <= '0;
      dvs           <= '0;
      prem          <= '0;
      cnt           <= '0;
      bus.Busy      <= 1'b0;
      bus.Done      <= 1'b0;
      bus.Quotient  <= '0;
      bus.Remainder <= '0;
      bus.DivZero   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.Done <= 1'b0;
          if (bus.Start) begin
            if (bus.B == '0) begin
              state         <= DONE;
              bus.Done      <= 1'b1;
              bus.Quotient  <= '1;
              bus.Remainder <= bus.A;
              bus.DivZero   <= 1'b1;
            end else begin
              dvd      <= bus.A;
              dvs      <= bus.B;
              prem     <= '0;
              cnt      <= '0;
              state    <= CALC;
              bus.Busy <= 1'b1;
            end
          end
        end
        CALC: begin
          dvd  <= dvd_nxt;
          prem <= prem_nxt;
          cnt  <= cnt + CW'(1);
          // Results become visible only on the final iteration edge.
          if (cnt == CW'(WIDTH - 1)) begin
            state         <= DONE;
            bus.Busy      <= 1'b0;
            bus.Done      <= 1'b1;
            bus.Quotient  <= dvd_nxt;
            bus.Remainder <= prem_nxt[WIDTH-1:0];
            bus.DivZero   <= 1'b0;
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.Done <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          bus.Busy <= 1'b0;
          bus.Done <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_restoring_divider.sv
// Directed and reference-model checks of restoring_divider at WIDTH=4 and WIDTH=8.
module tb_restoring_divider;
  logic Clk;
  logic Rst_n;
  int   n_chk;
  int   n_fail;

  restoring_divider_if #(.WIDTH(4)) d4();
  restoring_divider_if #(.WIDTH(8)) d8();

  restoring_divider #(.WIDTH(4)) u4 (.Clk(Clk), .Rst_n(Rst_n), .bus(d4.slave));
  restoring_divider #(.WIDTH(8)) u8 (.Clk(Clk), .Rst_n(Rst_n), .bus(d8.slave));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] q;
    logic [3:0] r;
    logic       dz;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Issue one WIDTH=4 divide from an IDLE cycle and check latency, Busy, results and pulse width.
  task automatic op4(input logic [3:0] a, input logic [3:0] b,
                     input logic [3:0] eq, input logic [3:0] er, input logic edz,
                     input string tag);
    int lat;
    int busy_n;
    d4.Start = 1'b1; d4.A = a; d4.B = b;
    tick();
    d4.Start = 1'b0; d4.A = ~a; d4.B = ~b;
    lat = 1; busy_n = 0;
    while (!d4.Done && lat < 40) begin
      if (d4.Busy) busy_n++;
      tick();
      lat++;
    end
    check({tag, " done"}, d4.Done, 1);
    check({tag, " latency"}, lat, (b == 0) ? 1 : 5);
    check({tag, " busy cycles"}, busy_n, (b == 0) ? 0 : 4);
    check({tag, " quotient"}, d4.Quotient, eq);
    check({tag, " remainder"}, d4.Remainder, er);
    check({tag, " divzero"}, d4.DivZero, edz);
    check({tag, " busy in done"}, d4.Busy, 0);
    tick();
    check({tag, " done pulse width"}, d4.Done, 0);
    check({tag, " quotient hold"}, d4.Quotient, eq);
  endtask

  initial begin
    int pulses;
    int last_t;
    int t;
    logic [3:0] eq;
    logic [3:0] er;
    logic [7:0] a8;
    logic [7:0] b8;
    n_chk = 0; n_fail = 0;

    vecs[0]  = '{a: 4'd13, b: 4'd3,  q: 4'd4,  r: 4'd1, dz: 1'b0};
    vecs[1]  = '{a: 4'd15, b: 4'd1,  q: 4'd15, r: 4'd0, dz: 1'b0};
    vecs[2]  = '{a: 4'd2,  b: 4'd9,  q: 4'd0,  r: 4'd2, dz: 1'b0};
    vecs[3]  = '{a: 4'd0,  b: 4'd5,  q: 4'd0,  r: 4'd0, dz: 1'b0};
    vecs[4]  = '{a: 4'd7,  b: 4'd0,  q: 4'd15, r: 4'd7, dz: 1'b1};
    vecs[5]  = '{a: 4'd8,  b: 4'd2,  q: 4'd4,  r: 4'd0, dz: 1'b0};
    vecs[6]  = '{a: 4'd14, b: 4'd4,  q: 4'd3,  r: 4'd2, dz: 1'b0};
    vecs[7]  = '{a: 4'd10, b: 4'd3,  q: 4'd3,  r: 4'd1, dz: 1'b0};
    vecs[8]  = '{a: 4'd15, b: 4'd15, q: 4'd1,  r: 4'd0, dz: 1'b0};
    vecs[9]  = '{a: 4'd0,  b: 4'd0,  q: 4'd15, r: 4'd0, dz: 1'b1};
    vecs[10] = '{a: 4'd9,  b: 4'd2,  q: 4'd4,  r: 4'd1, dz: 1'b0};
    vecs[11] = '{a: 4'd15, b: 4'd2,  q: 4'd7,  r: 4'd1, dz: 1'b0};

    d4.Start = 1'b0; d4.A = '0; d4.B = '0;
    d8.Start = 1'b0; d8.A = '0; d8.B = '0;
    Rst_n = 1'b0;
    tick(); tick();
    check("reset busy", d4.Busy, 0);
    check("reset done", d4.Done, 0);
    check("reset quotient", d4.Quotient, 0);
    check("reset remainder", d4.Remainder, 0);
    check("reset divzero", d4.DivZero, 0);
    Rst_n = 1'b1;
    tick();

    foreach (vecs[i])
      op4(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz, $sformatf("vec%0d", i));

    // Start and operand changes during CALC must not disturb the accepted 13/3.
    d4.Start = 1'b1; d4.A = 4'd13; d4.B = 4'd3;
    tick();
    d4.A = 4'd9; d4.B = 4'd2;
    pulses = 0;
    for (int c = 1; c <= 12; c++) begin
      if (c == 2) check("ignore quotient held mid-calc", d4.Quotient, 7);
      if (c == 3) begin d4.Start = 1'b0; d4.A = 4'd1; d4.B = 4'd1; end
      if (d4.Done) begin
        pulses++;
        check("ignore quotient", d4.Quotient, 4);
        check("ignore remainder", d4.Remainder, 1);
      end
      tick();
    end
    check("ignore done pulses", pulses, 1);

    // Start held high: one completion every WIDTH+2 cycles.
    d4.Start = 1'b1; d4.A = 4'd14; d4.B = 4'd4;
    pulses = 0; last_t = 0; t = 0;
    while (pulses < 3 && t < 60) begin
      tick();
      t++;
      if (d4.Done) begin
        pulses++;
        check("held quotient", d4.Quotient, 3);
        check("held remainder", d4.Remainder, 2);
        if (pulses > 1) check("held interval", t - last_t, 6);
        last_t = t;
      end
    end
    d4.Start = 1'b0;
    check("held pulses", pulses, 3);
    tick(); tick();

    // Reset mid-CALC discards the operation.
    op4(4'd13, 4'd3, 4'd4, 4'd1, 1'b0, "pre-reset");
    d4.Start = 1'b1; d4.A = 4'd11; d4.B = 4'd2;
    tick();
    d4.Start = 1'b0;
    tick();
    Rst_n = 1'b0;
    #1;
    check("midrst busy", d4.Busy, 0);
    check("midrst quotient", d4.Quotient, 0);
    check("midrst remainder", d4.Remainder, 0);
    tick();
    Rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      if (d4.Done) pulses++;
      tick();
    end
    check("midrst no done", pulses, 0);
    op4(4'd10, 4'd3, 4'd3, 4'd1, 1'b0, "post-reset");

    // Exhaustive WIDTH=4 sweep.
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++) begin
        eq = (b == 0) ? 4'd15 : 4'(a / b);
        er = (b == 0) ? 4'(a) : 4'(a % b);
        op4(4'(a), 4'(b), eq, er, (b == 0), $sformatf("sweep %0d/%0d", a, b));
      end

    // WIDTH=8: corners then random pairs.
    for (int k = 0; k < 40; k++) begin
      int lat;
      case (k)
        0: begin a8 = 8'd255; b8 = 8'd1;   end
        1: begin a8 = 8'd200; b8 = 8'd0;   end
        2: begin a8 = 8'd5;   b8 = 8'd255; end
        3: begin a8 = 8'd255; b8 = 8'd255; end
        default: begin a8 = 8'($urandom_range(0, 255)); b8 = 8'($urandom_range(1, 255)); end
      endcase
      d8.Start = 1'b1; d8.A = a8; d8.B = b8;
      tick();
      d8.Start = 1'b0; d8.A = ~a8; d8.B = 8'd0;
      lat = 1;
      while (!d8.Done && lat < 40) begin tick(); lat++; end
      check($sformatf("w8 %0d/%0d latency", a8, b8), lat, (b8 == 0) ? 1 : 9);
      check($sformatf("w8 %0d/%0d quotient", a8, b8), d8.Quotient, (b8 == 0) ? 255 : a8 / b8);
      check($sformatf("w8 %0d/%0d remainder", a8, b8), d8.Remainder, (b8 == 0) ? a8 : a8 % b8);
      check($sformatf("w8 %0d/%0d divzero", a8, b8), d8.DivZero, (b8 == 0));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
